mem_access_unit: RTL



---
 rtl/mem_pkg.sv | 37 +++
 rtl/mem_addr_gen.sv | 19 +
 rtl/mem_access_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port: widths, field positions,
// request opcodes and the access-unit state encoding.
package mem_pkg;

  localparam int MEM_ADDR_W = 12;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_OFF_W  = 9;

  // Byte address layout: [11:10] selects the memory block, [9:1] the word inside it.
  localparam int BLK_SEL_HI  = 11;
  localparam int BLK_SEL_LO  = 10;
  localparam int WORD_IDX_HI = 9;
  localparam int WORD_IDX_LO = 1;

  typedef enum logic [1:0] {
    OP_LW  = 2'b00,
    OP_LWI = 2'b01,
    OP_SW  = 2'b10,
    OP_SWI = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_INDIR,
    ST_RESP
  } mau_state_e;

  function automatic logic op_is_store(input mem_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_indirect(input mem_op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/mem_addr_gen.sv
// Effective byte address: base plus word offset scaled to bytes, wrapping
// modulo the address space.
module mem_addr_gen #(
  parameter int ADDR_W = 12,
  parameter int OFF_W  = 9
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [OFF_W-1:0]  offset,
  output logic [ADDR_W-1:0] eff
);

  localparam int SUM_W = (ADDR_W > OFF_W + 1) ? ADDR_W : OFF_W + 1;

  logic [SUM_W-1:0] sum;

  assign sum = SUM_W'(base) + SUM_W'({offset, 1'b0});
  assign eff = sum[ADDR_W-1:0];

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory port: accepts load/store requests,
// drives the memory pins from latched state and returns read data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int OFF_W       = MEM_OFF_W,
  parameter int HW_INDIRECT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [OFF_W-1:0]  req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] address_bus,
  input  logic [DATA_W-1:0] data_bus,
  output logic [DATA_W-1:0] incoming_data_bus,
  output logic              write_mode,
  output logic              doubleRead,
  output logic              doubleWrite
);

  mau_state_e        state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [ADDR_W-1:0] eff_q, eff_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] eff_new;

  mem_addr_gen #(
    .ADDR_W(ADDR_W),
    .OFF_W (OFF_W)
  ) u_addr_gen (
    .base  (req_base),
    .offset(req_offset),
    .eff   (eff_new)
  );

  // Memory pins are decoded from state and latched registers only, so the
  // request inputs never reach the memory combinationally.
  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    eff_d             = eff_q;
    ptr_d             = ptr_q;
    wdata_d           = wdata_q;
    rdata_d           = rdata_q;
    req_ready         = 1'b0;
    rsp_valid         = 1'b0;
    address_bus       = '0;
    incoming_data_bus = '0;
    write_mode        = 1'b0;
    doubleRead        = 1'b0;
    doubleWrite       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = mem_op_e'(req_op);
          eff_d   = eff_new;
          wdata_d = req_wdata;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        address_bus = eff_q;
        if (op_is_indirect(op_q) && HW_INDIRECT == 0) begin
          ptr_d   = data_bus[ADDR_W-1:0];
          state_d = ST_INDIR;
        end else begin
          state_d = ST_RESP;
          if (op_is_store(op_q)) begin
            write_mode        = 1'b1;
            doubleWrite       = (HW_INDIRECT != 0) && op_is_indirect(op_q);
            incoming_data_bus = wdata_q;
            rdata_d           = '0;
          end else begin
            doubleRead = (HW_INDIRECT != 0) && op_is_indirect(op_q);
            rdata_d    = data_bus;
          end
        end
      end
      ST_INDIR: begin
        address_bus = ptr_q;
        state_d     = ST_RESP;
        if (op_is_store(op_q)) begin
          write_mode        = 1'b1;
          incoming_data_bus = wdata_q;
          rdata_d           = '0;
        end else begin
          rdata_d = data_bus;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign rsp_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LW;
      eff_q   <= '0;
      ptr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      eff_q   <= eff_d;
      ptr_q   <= ptr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
